// File: rtl/uart_fifo.sv
// rtl/uart_fifo.sv - memory-mapped UART with TX/RX FIFOs, optional parity and runtime baud divisor
module uart_fifo #(
    parameter int                   DATA_BITS   = 8,
    parameter int                   FIFO_DEPTH  = 4,
    parameter int                   DIV_WIDTH   = 16,
    parameter logic [DIV_WIDTH-1:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        WE,
    input  logic        RE,
    input  logic [31:0] addr,
    input  logic [31:0] WD,
    input  logic        rxd,
    output logic        txd,
    output logic [31:0] RD,
    output logic        interrupt
);
    localparam int                   AW       = $clog2(FIFO_DEPTH);
    localparam logic [DIV_WIDTH-1:0] DIV_ONE  = 1;
    localparam logic [DIV_WIDTH-1:0] DIV_MIN  = 2;
    localparam logic [2:0]           LAST_BIT = 3'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    logic [5:0]           ctrl_q, ctrl_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [AW:0]          tx_wp_q, tx_wp_d, tx_rp_q, tx_rp_d;
    logic [AW:0]          rx_wp_q, rx_wp_d, rx_rp_q, rx_rp_d;
    state_t               tx_state_q, tx_state_d, rx_state_q, rx_state_d;
    logic [DIV_WIDTH-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
    logic [DIV_WIDTH-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
    logic [2:0]           tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d, rx_shift_q, rx_shift_d;
    logic                 tx_par_en_q, tx_par_en_d, tx_par_bit_q, tx_par_bit_d;
    logic                 rx_par_en_q, rx_par_en_d, rx_par_odd_q, rx_par_odd_d;
    logic                 txd_q, txd_d;
    logic [2:0]           rx_sync_q, rx_sync_d;
    logic                 ovr_q, ovr_d, ferr_q, ferr_d, perr_q, perr_d;
    logic                 irq_q, irq_d;

    logic [1:0] sel;
    logic       tx_empty, tx_full, rx_empty, rx_full, tx_busy;
    logic       tx_push, tx_load, rx_push, rx_pop, rx_store;
    logic       rx_line, rx_fall, ferr_set, perr_set;
    logic       unused_bits;

    assign sel      = addr[3:2];
    assign tx_empty = (tx_wp_q == tx_rp_q);
    assign tx_full  = (tx_wp_q[AW] != tx_rp_q[AW]) && (tx_wp_q[AW-1:0] == tx_rp_q[AW-1:0]);
    assign rx_empty = (rx_wp_q == rx_rp_q);
    assign rx_full  = (rx_wp_q[AW] != rx_rp_q[AW]) && (rx_wp_q[AW-1:0] == rx_rp_q[AW-1:0]);
    assign tx_busy  = (tx_state_q != S_IDLE);
    assign rx_pop   = RE && (sel == 2'd0) && !rx_empty;
    assign rx_store = rx_push && (!rx_full || rx_pop);
    assign rx_line  = rx_sync_q[1];
    assign rx_fall  = rx_sync_q[2] & ~rx_sync_q[1];
    assign txd       = txd_q;
    assign interrupt = irq_q;
    assign unused_bits = ^{addr[31:4], addr[1:0], WD};

    always_ff @(posedge clk) begin
        if (tx_push)  tx_mem[tx_wp_q[AW-1:0]] <= WD[DATA_BITS-1:0];
        if (rx_store) rx_mem[rx_wp_q[AW-1:0]] <= rx_shift_q;
    end

    // TX: a load happens from IDLE or at the end of STOP, which chains frames without a gap
    always_comb begin
        tx_state_d   = tx_state_q;
        tx_cnt_d     = tx_cnt_q;
        tx_div_d     = tx_div_q;
        tx_bit_d     = tx_bit_q;
        tx_shift_d   = tx_shift_q;
        tx_par_en_d  = tx_par_en_q;
        tx_par_bit_d = tx_par_bit_q;
        tx_load      = 1'b0;
        if (tx_state_q == S_IDLE) begin
            tx_load = !tx_empty;
        end else if (tx_cnt_q == tx_div_q - DIV_ONE) begin
            tx_cnt_d = '0;
            tx_div_d = div_q;
            case (tx_state_q)
                S_START: begin
                    tx_state_d = S_DATA;
                    tx_bit_d   = '0;
                end
                S_DATA: begin
                    tx_shift_d = tx_shift_q >> 1;
                    tx_bit_d   = tx_bit_q + 3'd1;
                    if (tx_bit_q == LAST_BIT) tx_state_d = tx_par_en_q ? S_PARITY : S_STOP;
                end
                S_PARITY: tx_state_d = S_STOP;
                default: begin
                    tx_state_d = S_IDLE;
                    tx_load    = !tx_empty;
                end
            endcase
        end else begin
            tx_cnt_d = tx_cnt_q + DIV_ONE;
        end
        if (tx_load) begin
            tx_state_d   = S_START;
            tx_cnt_d     = '0;
            tx_div_d     = div_q;
            tx_shift_d   = tx_mem[tx_rp_q[AW-1:0]];
            tx_par_en_d  = ctrl_q[0];
            tx_par_bit_d = (^tx_mem[tx_rp_q[AW-1:0]]) ^ ctrl_q[1];
        end
        tx_push = WE && (sel == 2'd0) && (!tx_full || tx_load);
        tx_wp_d = tx_wp_q + {{AW{1'b0}}, tx_push};
        tx_rp_d = tx_rp_q + {{AW{1'b0}}, tx_load};
        case (tx_state_q)
            S_START:  txd_d = 1'b0;
            S_DATA:   txd_d = tx_shift_q[0];
            S_PARITY: txd_d = tx_par_bit_q;
            default:  txd_d = 1'b1;
        endcase
    end

    always_comb begin
        rx_sync_d    = {rx_sync_q[1:0], ctrl_q[5] ? txd_q : rxd};
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q;
        rx_div_d     = rx_div_q;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        rx_par_en_d  = rx_par_en_q;
        rx_par_odd_d = rx_par_odd_q;
        rx_push      = 1'b0;
        ferr_set     = 1'b0;
        perr_set     = 1'b0;
        case (rx_state_q)
            S_IDLE: begin
                if (rx_fall) begin
                    rx_state_d   = S_START;
                    rx_cnt_d     = '0;
                    rx_div_d     = div_q;
                    rx_par_en_d  = ctrl_q[0];
                    rx_par_odd_d = ctrl_q[1];
                end
            end
            S_START: begin
                if (rx_cnt_q == (rx_div_q >> 1) - DIV_ONE) begin
                    rx_cnt_d   = '0;
                    rx_div_d   = div_q;
                    rx_bit_d   = '0;
                    rx_state_d = rx_line ? S_IDLE : S_DATA;
                end else begin
                    rx_cnt_d = rx_cnt_q + DIV_ONE;
                end
            end
            default: begin
                if (rx_cnt_q == rx_div_q - DIV_ONE) begin
                    rx_cnt_d = '0;
                    rx_div_d = div_q;
                    case (rx_state_q)
                        S_DATA: begin
                            rx_shift_d = {rx_line, rx_shift_q[DATA_BITS-1:1]};
                            rx_bit_d   = rx_bit_q + 3'd1;
                            if (rx_bit_q == LAST_BIT) rx_state_d = rx_par_en_q ? S_PARITY : S_STOP;
                        end
                        S_PARITY: begin
                            perr_set   = (^rx_shift_q) ^ rx_line ^ rx_par_odd_q;
                            rx_state_d = S_STOP;
                        end
                        default: begin
                            rx_push    = 1'b1;
                            ferr_set   = !rx_line;
                            rx_state_d = S_IDLE;
                        end
                    endcase
                end else begin
                    rx_cnt_d = rx_cnt_q + DIV_ONE;
                end
            end
        endcase
        rx_wp_d = rx_wp_q + {{AW{1'b0}}, rx_store};
        rx_rp_d = rx_rp_q + {{AW{1'b0}}, rx_pop};
    end

    // A new error event in the same cycle as a STATUS read wins over the clear
    always_comb begin
        ctrl_d = ctrl_q;
        div_d  = div_q;
        if (WE && sel == 2'd2) ctrl_d = WD[5:0];
        if (WE && sel == 2'd3) div_d = (WD[DIV_WIDTH-1:0] < DIV_MIN) ? DIV_MIN : WD[DIV_WIDTH-1:0];
        ovr_d  = ovr_q;
        ferr_d = ferr_q;
        perr_d = perr_q;
        if (RE && sel == 2'd1) begin
            ovr_d  = 1'b0;
            ferr_d = 1'b0;
            perr_d = 1'b0;
        end
        if (rx_push && !rx_store) ovr_d = 1'b1;
        if (ferr_set) ferr_d = 1'b1;
        if (perr_set) perr_d = 1'b1;
        irq_d = (ctrl_q[2] & !rx_empty) | (ctrl_q[3] & tx_empty & !tx_busy)
              | (ctrl_q[4] & (ovr_q | ferr_q | perr_q));
    end

    always_comb begin
        RD = '0;
        case (sel)
            2'd0:    if (!rx_empty) RD[DATA_BITS-1:0] = rx_mem[rx_rp_q[AW-1:0]];
            2'd1:    RD[7:0] = {tx_busy, perr_q, ferr_q, ovr_q, tx_full, tx_empty, rx_full, !rx_empty};
            2'd2:    RD[5:0] = ctrl_q;
            default: RD[DIV_WIDTH-1:0] = div_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q       <= '0;
            div_q        <= DEFAULT_DIV;
            tx_wp_q      <= '0;
            tx_rp_q      <= '0;
            rx_wp_q      <= '0;
            rx_rp_q      <= '0;
            tx_state_q   <= S_IDLE;
            rx_state_q   <= S_IDLE;
            tx_cnt_q     <= '0;
            tx_div_q     <= DEFAULT_DIV;
            rx_cnt_q     <= '0;
            rx_div_q     <= DEFAULT_DIV;
            tx_bit_q     <= '0;
            rx_bit_q     <= '0;
            tx_shift_q   <= '0;
            rx_shift_q   <= '0;
            tx_par_en_q  <= 1'b0;
            tx_par_bit_q <= 1'b0;
            rx_par_en_q  <= 1'b0;
            rx_par_odd_q <= 1'b0;
            txd_q        <= 1'b1;
            rx_sync_q    <= 3'b111;
            ovr_q        <= 1'b0;
            ferr_q       <= 1'b0;
            perr_q       <= 1'b0;
            irq_q        <= 1'b0;
        end else begin
            ctrl_q       <= ctrl_d;
            div_q        <= div_d;
            tx_wp_q      <= tx_wp_d;
            tx_rp_q      <= tx_rp_d;
            rx_wp_q      <= rx_wp_d;
            rx_rp_q      <= rx_rp_d;
            tx_state_q   <= tx_state_d;
            rx_state_q   <= rx_state_d;
            tx_cnt_q     <= tx_cnt_d;
            tx_div_q     <= tx_div_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_div_q     <= rx_div_d;
            tx_bit_q     <= tx_bit_d;
            rx_bit_q     <= rx_bit_d;
            tx_shift_q   <= tx_shift_d;
            rx_shift_q   <= rx_shift_d;
            tx_par_en_q  <= tx_par_en_d;
            tx_par_bit_q <= tx_par_bit_d;
            rx_par_en_q  <= rx_par_en_d;
            rx_par_odd_q <= rx_par_odd_d;
            txd_q        <= txd_d;
            rx_sync_q    <= rx_sync_d;
            ovr_q        <= ovr_d;
            ferr_q       <= ferr_d;
            perr_q       <= perr_d;
            irq_q        <= irq_d;
        end
    end
endmodule

// File: tb/tb_uart_fifo.sv
// tb/tb_uart_fifo.sv - directed self-checking bench for uart_fifo
module tb_uart_fifo;
    localparam int DB    = 8;
    localparam int DEPTH = 4;
    localparam logic [3:0] A_DATA = 4'h0, A_STAT = 4'h4, A_CTRL = 4'h8, A_DIV = 4'hC;

    logic        clk = 1'b0, reset = 1'b0, WE = 1'b0, RE = 1'b0, rxd = 1'b1;
    logic [31:0] addr = '0, WD = '0;
    logic        txd, interrupt;
    logic [31:0] RD;

    int errors = 0, checks = 0;
    int cyc = 0;
    int mon_div = 4;
    logic mon_par = 1'b0;
    logic [7:0] mon_data[$];
    logic       mon_pbit[$];
    logic       mon_stop[$];
    int         mon_t[$];
    logic [31:0] rdv;
    logic [9:0]  frame;

    uart_fifo #(.DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .DIV_WIDTH(16), .DEFAULT_DIV(16'd434)) dut (
        .clk(clk), .reset(reset), .WE(WE), .RE(RE), .addr(addr), .WD(WD),
        .rxd(rxd), .txd(txd), .RD(RD), .interrupt(interrupt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Serial decoder on txd, sampling mid-bit from the first low cycle of each start bit
    always begin : tx_monitor
        logic [7:0] d;
        logic       p;
        int         t0;
        @(negedge clk);
        if (reset && txd === 1'b0) begin
            t0 = cyc;
            d  = '0;
            p  = 1'b0;
            repeat (mon_div / 2) @(negedge clk);
            for (int k = 0; k < DB; k++) begin
                repeat (mon_div) @(negedge clk);
                d[k] = txd;
            end
            if (mon_par) begin
                repeat (mon_div) @(negedge clk);
                p = txd;
            end
            repeat (mon_div) @(negedge clk);
            mon_data.push_back(d);
            mon_pbit.push_back(p);
            mon_stop.push_back(txd);
            mon_t.push_back(t0);
        end
    end

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        addr = 32'h4000_0000 | {28'd0, a};
        WD   = d;
        WE   = 1'b1;
        @(negedge clk);
        WE = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic pop, output logic [31:0] d);
        addr = 32'h4000_0000 | {28'd0, a};
        RE   = pop;
        #1 d = RD;
        @(negedge clk);
        RE = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] d, input logic has_par, input logic par,
                           input logic stop, input int div);
        rxd = 1'b0;
        repeat (div) @(negedge clk);
        for (int k = 0; k < DB; k++) begin
            rxd = d[k];
            repeat (div) @(negedge clk);
        end
        if (has_par) begin
            rxd = par;
            repeat (div) @(negedge clk);
        end
        rxd = stop;
        repeat (div) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * div) @(negedge clk);
    endtask

    task automatic wait_mon(input int n, input int budget);
        int i;
        i = 0;
        while (mon_data.size() < n && i < budget) begin
            @(negedge clk);
            i++;
        end
    endtask

    task automatic clear_mon();
        mon_data.delete();
        mon_pbit.delete();
        mon_stop.delete();
        mon_t.delete();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b1;

        rd(A_STAT, 1'b0, rdv); check("reset_status", rdv, 32'h04);
        check("reset_txd", txd, 1);
        check("reset_irq", interrupt, 0);
        rd(A_DIV, 1'b0, rdv);  check("reset_div", rdv, 434);
        rd(A_CTRL, 1'b0, rdv); check("reset_ctrl", rdv, 0);
        rd(A_DATA, 1'b1, rdv); check("empty_data_read", rdv, 0);
        wr(A_DIV, 32'd0);
        rd(A_DIV, 1'b0, rdv);  check("div_min_clamp", rdv, 2);

        wr(A_DIV, 32'd4);
        wr(A_CTRL, 32'h0);
        wr(A_DATA, 32'hA5);
        frame = {1'b1, 8'hA5, 1'b0};
        @(negedge clk);
        check("tx_latency_high", txd, 1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            check($sformatf("a5_cycle%0d", i), txd, frame[i / 4]);
        end
        rd(A_STAT, 1'b0, rdv); check("a5_not_busy", rdv, 32'h04);

        clear_mon();
        mon_par = 1'b1;
        wr(A_CTRL, 32'h25);
        wr(A_DATA, 32'h3C);
        wr(A_DATA, 32'h81);
        repeat (36) @(negedge clk);
        check("lb_irq_before", interrupt, 0);
        repeat (16) @(negedge clk);
        check("lb_irq_after_first", interrupt, 1);
        wait_mon(2, 200);
        check("lb_frames", mon_data.size(), 2);
        if (mon_data.size() == 2) begin
            check("lb_data0", mon_data[0], 8'h3C);
            check("lb_par0", mon_pbit[0], 0);
            check("lb_stop0", mon_stop[0], 1);
            check("lb_data1", mon_data[1], 8'h81);
            check("lb_par1", mon_pbit[1], 0);
            check("lb_gap", mon_t[1] - mon_t[0], 44);
        end
        repeat (12) @(negedge clk);
        rd(A_DATA, 1'b1, rdv); check("lb_read0", rdv, 8'h3C);
        rd(A_DATA, 1'b1, rdv); check("lb_read1", rdv, 8'h81);
        repeat (2) @(negedge clk);
        check("lb_irq_cleared", interrupt, 0);
        rd(A_STAT, 1'b0, rdv); check("lb_status", rdv, 32'h04);

        clear_mon();
        mon_par = 1'b0;
        wr(A_CTRL, 32'h0);
        for (int i = 0; i < DEPTH + 2; i++) wr(A_DATA, 32'h10 + i);
        rd(A_STAT, 1'b0, rdv); check("ovf_tx_full", rdv, 32'h88);
        wait_mon(DEPTH + 2, 400);
        check("ovf_frames", mon_data.size(), DEPTH + 1);
        if (mon_data.size() == DEPTH + 1) begin
            for (int i = 0; i < DEPTH + 1; i++) check($sformatf("ovf_data%0d", i), mon_data[i], 8'h10 + i);
            check("ovf_gap", mon_t[DEPTH] - mon_t[0], 40 * DEPTH);
        end
        rd(A_STAT, 1'b0, rdv); check("ovf_status_idle", rdv, 32'h04);

        clear_mon();
        wr(A_CTRL, 32'h30);
        for (int i = 0; i < DEPTH + 1; i++) wr(A_DATA, 32'h50 + i);
        wait_mon(DEPTH + 1, 400);
        repeat (20) @(negedge clk);
        rd(A_STAT, 1'b0, rdv); check("rxovr_status", rdv, 32'h17);
        check("rxovr_irq", interrupt, 1);
        rd(A_STAT, 1'b1, rdv); check("rxovr_status_clr", rdv, 32'h17);
        repeat (2) @(negedge clk);
        check("rxovr_irq_cleared", interrupt, 0);
        rd(A_STAT, 1'b0, rdv); check("rxovr_status_after", rdv, 32'h07);
        for (int i = 0; i < DEPTH; i++) begin
            rd(A_DATA, 1'b1, rdv); check($sformatf("rxovr_read%0d", i), rdv, 32'h50 + i);
        end
        rd(A_STAT, 1'b0, rdv); check("rxovr_drained", rdv, 32'h04);

        wr(A_CTRL, 32'h0);
        wr(A_DIV, 32'd8);
        send_rx(8'h5A, 1'b0, 1'b0, 1'b0, 8);
        rd(A_STAT, 1'b0, rdv); check("ferr_status", rdv, 32'h25);
        rd(A_DATA, 1'b1, rdv); check("ferr_data", rdv, 32'h5A);
        rd(A_STAT, 1'b1, rdv);
        rd(A_STAT, 1'b0, rdv); check("ferr_cleared", rdv, 32'h04);

        rxd = 1'b0;
        repeat (3) @(negedge clk);
        rxd = 1'b1;
        repeat (20) @(negedge clk);
        rd(A_STAT, 1'b0, rdv); check("glitch_no_push", rdv, 32'h04);
        send_rx(8'hC3, 1'b0, 1'b0, 1'b1, 8);
        rd(A_STAT, 1'b0, rdv); check("after_glitch_status", rdv, 32'h05);
        rd(A_DATA, 1'b1, rdv); check("after_glitch_data", rdv, 32'hC3);

        wr(A_CTRL, 32'h01);
        send_rx(8'h07, 1'b1, 1'b0, 1'b1, 8);
        rd(A_STAT, 1'b1, rdv); check("perr_status", rdv, 32'h45);
        rd(A_DATA, 1'b1, rdv); check("perr_data", rdv, 32'h07);
        send_rx(8'h07, 1'b1, 1'b1, 1'b1, 8);
        rd(A_STAT, 1'b0, rdv); check("par_ok_status", rdv, 32'h05);
        rd(A_DATA, 1'b1, rdv); check("par_ok_data", rdv, 32'h07);

        wr(A_CTRL, 32'h08);
        repeat (2) @(negedge clk);
        check("irq_tx_empty", interrupt, 1);

        wr(A_CTRL, 32'h0);
        wr(A_DIV, 32'd4);
        wr(A_DATA, 32'h00);
        repeat (6) @(negedge clk);
        check("midframe_txd_low", txd, 0);
        reset = 1'b0;
        #1 check("async_reset_txd", txd, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        rd(A_STAT, 1'b0, rdv); check("post_reset_status", rdv, 32'h04);
        rd(A_DIV, 1'b0, rdv);  check("post_reset_div", rdv, 434);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
